// File: rtl/simon_pkg.sv
// simon_pkg: shared colour/state types and the one-hot colour encoder for the Simon input path.
package simon_pkg;
    localparam int SEQ_LEN = 33;
    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} colour_t;
    typedef enum logic [2:0] {IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL} cap_state_t;
    function automatic colour_t onehot_to_colour(input logic [3:0] oh);
        return oh[3] ? COL3 : oh[2] ? COL2 : oh[1] ? COL1 : COL0;
    endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus stability counter for one raw button.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw_i,
    output logic btn_o
);
    localparam int CW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    // The counter only runs while the synchronised level disagrees with the debounced one.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) lvl_d = ~lvl_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw_i};
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
        end
    end
    assign btn_o = lvl_q;
endmodule

// File: rtl/player_capture.sv
// player_capture: debounces the player buttons and checks each press against the round sequence.
// Define PLAYER_TIMEOUT_EN to fail a round when no press arrives within TIMEOUT_CYCLES.
module player_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SEQ_LEN = simon_pkg::SEQ_LEN
`ifdef PLAYER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              buttons,
    input  logic [SEQ_LEN-1:0][1:0] segment,
    input  logic [5:0]              round_len,
    input  logic                    start,
    output logic [3:0]              player_input,
    output logic [5:0]              check_idx,
    output logic                    press_valid,
    output logic [1:0]              press_colour,
    output logic                    round_pass,
    output logic                    round_fail,
    output logic                    busy
);
    import simon_pkg::*;

    cap_state_t state_q, state_d;
    logic [5:0] len_q, len_d, idx_q, idx_d;
    logic       pv_q, pv_d, pass_q, fail_q;
    colour_t    col_q, col_d, pi_col;
    logic       pi_onehot, pi_zero, col_match;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .btn_raw_i(buttons[i]),
            .btn_o    (player_input[i])
        );
    end

    assign pi_zero   = player_input == 4'b0000;
    assign pi_onehot = $onehot(player_input);
    assign pi_col    = onehot_to_colour(player_input);
    assign col_match = pi_col == colour_t'(segment[idx_q]);

`ifdef PLAYER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    // Held at zero outside WAIT_PRESS, so every entry starts a fresh count.
    assign tmo_d   = (state_q == WAIT_PRESS) ? tmo_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_q <= '0;
        else tmo_q <= tmo_d;
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        pv_d    = 1'b0;
        col_d   = col_q;
        case (state_q)
            IDLE: if (start) begin
                len_d   = (32'(round_len) > SEQ_LEN) ? 6'(SEQ_LEN) : round_len;
                idx_d   = '0;
                state_d = (round_len == 6'd0) ? PASS : ARM;
            end
            ARM: state_d = pi_zero ? WAIT_PRESS : ARM;
            // A press has priority over the timeout; multi-button presses fail silently.
            WAIT_PRESS: if (pi_onehot) begin
                pv_d    = 1'b1;
                col_d   = pi_col;
                state_d = col_match ? WAIT_RELEASE : FAIL;
            end else if (!pi_zero || tmo_hit) begin
                state_d = FAIL;
            end
            WAIT_RELEASE: if (pi_zero) begin
                if (idx_q == len_q - 6'd1) state_d = PASS;
                else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = WAIT_PRESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            pv_q    <= 1'b0;
            col_q   <= COL0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            pv_q    <= pv_d;
            col_q   <= col_d;
            pass_q  <= state_q == PASS;
            fail_q  <= state_q == FAIL;
        end
    end

    assign check_idx    = idx_q;
    assign press_valid  = pv_q;
    assign press_colour = col_q;
    assign round_pass   = pass_q;
    assign round_fail   = fail_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_player_capture.sv
// tb_player_capture: directed checks of debounce, round checking, failures, reset and timeout.
module tb_player_capture;
    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [3:0]       buttons = '0;
    logic [32:0][1:0] segment = '0;
    logic [5:0]       round_len = '0;
    logic             start = 1'b0;
    logic [3:0]       player_input;
    logic [5:0]       check_idx;
    logic             press_valid;
    logic [1:0]       press_colour;
    logic             round_pass;
    logic             round_fail;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int pv_n = 0;
    int pass_n = 0;
    int fail_n = 0;

    always #5 clk = ~clk;

    player_capture #(
        .DEBOUNCE_CYCLES(4)
`ifdef PLAYER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(50)
`endif
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .buttons     (buttons),
        .segment     (segment),
        .round_len   (round_len),
        .start       (start),
        .player_input(player_input),
        .check_idx   (check_idx),
        .press_valid (press_valid),
        .press_colour(press_colour),
        .round_pass  (round_pass),
        .round_fail  (round_fail),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (press_valid) pv_n <= pv_n + 1;
        if (round_pass) pass_n <= pass_n + 1;
        if (round_fail) fail_n <= fail_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [5:0] len);
        round_len = len;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Leaves the button held, one cycle after the press_valid pulse.
    task automatic press(input logic [3:0] b, input logic [1:0] col, input logic [5:0] idx);
        buttons = b;
        tick(6);
        chk("press_level", player_input, b);
        chk("press_early", press_valid, 0);
        tick(1);
        chk("press_valid", press_valid, 1);
        chk("press_colour", press_colour, col);
        chk("press_idx", check_idx, idx);
        tick(1);
        chk("press_once", press_valid, 0);
    endtask

    task automatic release_all();
        buttons = '0;
        tick(6);
        chk("release_level", player_input, 0);
    endtask

    initial begin
        tick(3);
        chk("rst_pin", player_input, 0);
        chk("rst_idx", check_idx, 0);
        chk("rst_pv", press_valid, 0);
        chk("rst_col", press_colour, 0);
        chk("rst_pass", round_pass, 0);
        chk("rst_fail", round_fail, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick(1);

        for (int i = 0; i < 10; i++) begin
            buttons[2] = ~buttons[2];
            tick(2);
            chk("bounce_hold", player_input, 0);
        end
        buttons[2] = 1'b1;
        tick(5);
        chk("bounce_5", player_input, 0);
        tick(1);
        chk("bounce_6", player_input, 4'b0100);
        release_all();
        chk("idle_no_press", pv_n, 0);

        segment[0] = 2'b01;
        segment[1] = 2'b11;
        segment[2] = 2'b00;
        pulse_start(6'd3);
        chk("ok_busy", busy, 1);
        chk("ok_idx0", check_idx, 0);
        press(4'b0010, 2'd1, 6'd0);
        release_all();
        tick(1);
        chk("ok_idx1", check_idx, 1);
        press(4'b1000, 2'd3, 6'd1);
        release_all();
        tick(1);
        chk("ok_idx2", check_idx, 2);
        press(4'b0001, 2'd0, 6'd2);
        release_all();
        tick(1);
        chk("ok_pass_early", round_pass, 0);
        tick(1);
        chk("ok_pass", round_pass, 1);
        chk("ok_busy_end", busy, 0);
        chk("ok_idx_hold", check_idx, 2);
        tick(1);
        chk("ok_pass_once", round_pass, 0);
        chk("ok_pv_count", pv_n, 3);
        chk("ok_pass_count", pass_n, 1);
        chk("ok_fail_count", fail_n, 0);

        segment[0] = 2'b10;
        pulse_start(6'd1);
        buttons = 4'b0001;
        tick(7);
        chk("wrong_pv", press_valid, 1);
        chk("wrong_col", press_colour, 0);
        chk("wrong_fail_early", round_fail, 0);
        chk("wrong_busy", busy, 1);
        tick(1);
        chk("wrong_fail", round_fail, 1);
        chk("wrong_busy_drop", busy, 0);
        tick(1);
        chk("wrong_fail_once", round_fail, 0);
        release_all();
        chk("wrong_fail_count", fail_n, 1);

        segment[0] = 2'b00;
        pulse_start(6'd1);
        tick(1);
        buttons = 4'b0101;
        tick(6);
        chk("multi_level", player_input, 4'b0101);
        tick(1);
        chk("multi_no_pv", press_valid, 0);
        tick(1);
        chk("multi_fail", round_fail, 1);
        chk("multi_no_pv2", press_valid, 0);
        release_all();
        chk("multi_pv_count", pv_n, 4);
        chk("multi_fail_count", fail_n, 2);

        buttons = 4'b0010;
        tick(6);
        chk("held_level", player_input, 4'b0010);
        segment[0] = 2'b01;
        pulse_start(6'd1);
        tick(10);
        chk("held_no_pv", pv_n, 4);
        chk("held_busy", busy, 1);
        release_all();
        tick(1);
        press(4'b0010, 2'd1, 6'd0);
        release_all();
        tick(2);
        chk("held_pass", round_pass, 1);
        chk("held_pv_count", pv_n, 5);

        segment[0] = 2'b11;
        segment[1] = 2'b10;
        pulse_start(6'd2);
        press(4'b1000, 2'd3, 6'd0);
        release_all();
        tick(1);
        press(4'b0100, 2'd2, 6'd1);
        chk("mid_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pin", player_input, 0);
        chk("arst_idx", check_idx, 0);
        chk("arst_col", press_colour, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pv", press_valid, 0);
        chk("arst_pass", round_pass, 0);
        chk("arst_fail", round_fail, 0);
        buttons = '0;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        pulse_start(6'd0);
        chk("zero_pass_early", round_pass, 0);
        chk("zero_busy", busy, 1);
        tick(1);
        chk("zero_pass", round_pass, 1);
        chk("zero_busy_end", busy, 0);
        tick(1);
        chk("zero_pass_once", round_pass, 0);

        segment[0] = 2'b00;
        pulse_start(6'd1);
        tick(1);
        press(4'b0001, 2'd0, 6'd0);
        release_all();
        tick(2);
        chk("after_rst_pass", round_pass, 1);

`ifdef PLAYER_TIMEOUT_EN
        pulse_start(6'd1);
        tick(51);
        chk("tmo_early", round_fail, 0);
        chk("tmo_busy", busy, 1);
        tick(1);
        chk("tmo_fail", round_fail, 1);
        chk("tmo_fail_count", fail_n, 3);
`else
        pulse_start(6'd1);
        tick(1000);
        chk("no_tmo_fail", fail_n, 2);
        chk("no_tmo_busy", busy, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/player_capture.md
# player_capture

Input-side counterpart of the colour flasher. Synchronises and debounces the four raw player buttons, exposes the debounced levels for the LED display path, and encodes each accepted press into a 2-bit colour. Checks every press against the stored round sequence, advances the check index, and reports round pass/fail to the game FSM.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised samples required to change a debounced button level.
- `SEQ_LEN`, 33: sequence depth. Matches the segment store.
- `TIMEOUT_CYCLES`, 1000000: press timeout. Used only when `PLAYER_TIMEOUT_EN` is defined.
- `clk`, in, 1: single clock. All state is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `buttons`, in, 4: raw, asynchronous, active-high player buttons. Bit n is colour n.
- `segment`, in, [SEQ_LEN-1:0][1:0]: colour sequence for the current game.
- `round_len`, in, 6: number of entries to check this round. Sampled on `start`.
- `start`, in, 1: one-cycle pulse that begins checking a round.
- `player_input`, out, 4: debounced button levels. Feeds the display OR.
- `check_idx`, out, 6: index of the entry currently expected.
- `press_valid`, out, 1: one-cycle pulse when a press is accepted.
- `press_colour`, out, 2: encoded colour. Valid with `press_valid` and holds its value afterwards.
- `round_pass`, out, 1: one-cycle pulse when the round is completed correctly.
- `round_fail`, out, 1: one-cycle pulse on a wrong, multiple or timed-out press.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- **Synchronisation:** a 2-flop synchroniser per button.
- **Debounce counter:** one per button. It counts cycles where the synchronised level differs from the debounced level, and clears whenever they are equal. On the cycle where the count reaches DEBOUNCE_CYCLES-1 with a difference still present, the debounced level toggles and the counter clears.
- **Press definition:** debounced `player_input` going from 4'b0000 to exactly one-hot. Encoding is bit0→2'b00, bit1→2'b01, bit2→2'b10, bit3→2'b11.
- **IDLE:** `start` latches `len = min(round_len, SEQ_LEN)` and clears `check_idx`.
  - If `len == 0` → PASS.
  - Otherwise → ARM.
- **ARM:** waits until `player_input == 0`, then → WAIT_PRESS. Buttons held when `start` arrives are therefore never counted as a press.
- **WAIT_PRESS:**
  - One-hot input: pulse `press_valid`. If the colour equals `segment[check_idx]` → WAIT_RELEASE, otherwise → FAIL.
  - Non-zero, non-one-hot input (two or more buttons in the same cycle): → FAIL, with no `press_valid`.
- **WAIT_RELEASE:** extra buttons are ignored. When `player_input == 0`:
  - If `check_idx == len-1` → PASS.
  - Otherwise increment `check_idx` → WAIT_PRESS.
- **PASS / FAIL:** assert `round_pass` / `round_fail` for exactly one cycle, then → IDLE. `check_idx` holds its value for observation.
- **`start` while `busy`:** ignored.
- **`segment` / `round_len` changes mid-round:** `segment` is read live. `round_len` is used only at `start`.
- **Asynchronous reset, including mid-round:** returns to IDLE. All outputs go to 0, and debounced levels, counters and synchronisers clear.

## Timing
- **Raw button change to `player_input`:** 2 + DEBOUNCE_CYCLES cycles when the input is stable. Any bounce restarts the count.
- **`press_valid`:** asserts in the first cycle the one-hot level is present in WAIT_PRESS (registered, 1 cycle after `player_input` changes).
- **`round_fail` on a wrong colour:** the cycle after `press_valid`.
- **`round_pass`:** 2 cycles after the final release is seen on `player_input`.
- **`start` to ARM:** 1 cycle.
- **`round_len == 0`:** `round_pass` 2 cycles after `start`.

## Configuration
- **`PLAYER_TIMEOUT_EN` defined:** a cycle counter clears on every entry to WAIT_PRESS and counts while in WAIT_PRESS. When it reaches TIMEOUT_CYCLES → FAIL. A simultaneous press takes priority over the timeout.
- **`PLAYER_TIMEOUT_EN` undefined:** no counter is built, and WAIT_PRESS waits indefinitely.

## Structure
- **Package `simon_pkg`:**
  - `SEQ_LEN` = 33.
  - `colour_t` (2-bit enum, COL0..COL3).
  - `cap_state_t` (IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL).
  - `onehot_to_colour` function.
- **Sub-module `button_debounce`:** synchroniser plus counter for one bit, parameterised by DEBOUNCE_CYCLES. Instantiated 4 times.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Debounce:** toggle `buttons[2]` every 2 cycles for 20 cycles, then hold it high → `player_input` stays 0 during the bounce and becomes 4'b0100 exactly 6 cycles after the final edge.
- **Correct round:** segment = {01,11,00}, round_len=3, `start`, then press/release 4'b0010, 4'b1000, 4'b0001 → three `press_valid` pulses with colours 1,3,0, `check_idx` 0→1→2, one `round_pass`, no `round_fail`.
- **Wrong colour:** segment[0]=2'b10, press 4'b0001 → `press_valid` with colour 0, then `round_fail` the next cycle, `busy` drops.
- **Multi-press and held buttons:**
  - Press 4'b0101 together in WAIT_PRESS → `round_fail`, no `press_valid`.
  - Buttons held at `start` → no press is counted until they are released.
- **Reset and edge cases:**
  - Assert `reset_n` low while in WAIT_RELEASE → all outputs 0 immediately, and `start` after release works normally.
  - round_len=0 → `round_pass` 2 cycles after `start`.
- **Timeout (`PLAYER_TIMEOUT_EN`, TIMEOUT_CYCLES=50):** no input after `start` → `round_fail` after 50 cycles in WAIT_PRESS. Without the macro → no fail after 1000 cycles.
